// File: rtl/transmissor_serial_8bits_pkg.sv
// Shared definitions for the 8-bit serial byte link (transmitter and future receiver).
// Frame: start bit, 8 data bits LSB first, optional even parity, stop bit.
package transmissor_serial_8bits_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4
    } estado_t;

    localparam logic BIT_INICIO   = 1'b0;
    localparam logic BIT_PARADA   = 1'b1;
    localparam int   LARGURA_DADO = 8;

    // Bits per frame, start and stop included.
    function automatic int unsigned bits_quadro(input int unsigned hab_paridade);
        return (hab_paridade != 0) ? 32'd11 : 32'd10;
    endfunction

    function automatic logic paridade_par(input logic [LARGURA_DADO-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/transmissor_serial_8bits_divisor_bit.sv
// Bit-period divider: counts 0..DIVISOR-1 and flags the terminal count.
// i_limpa restarts the period so the first bit of a frame is full length.
module transmissor_serial_8bits_divisor_bit #(
    parameter int unsigned DIVISOR = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_limpa,
    output logic o_tick
);
    localparam int W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [W-1:0] r_cont;

    assign o_tick = (r_cont == W'(DIVISOR - 1));

    // Period counter; with DIVISOR=1 it stays at zero and ticks every cycle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cont <= '0;
        end else if (i_limpa || o_tick) begin
            r_cont <= '0;
        end else begin
            r_cont <= r_cont + W'(1);
        end
    end

endmodule

// File: rtl/transmissor_serial_8bits.sv
// Parallel-in serial-out byte transmitter with valid/ready input handshake.
// The line is registered and idles high; each bit lasts DIVISOR clocks.
module transmissor_serial_8bits
    import transmissor_serial_8bits_pkg::*;
#(
    parameter int unsigned DIVISOR      = 4,
    parameter int unsigned HAB_PARIDADE = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [LARGURA_DADO-1:0] dado,
    input  logic                    valido,
    output logic                    pronto,
    output logic                    ocupado,
    output logic                    serial
);
    estado_t                 r_estado;
    logic [LARGURA_DADO-1:0] r_desloc;
    logic                    r_paridade;
    logic [2:0]              r_indice;
    logic                    r_pronto;
    logic                    r_serial;
    logic                    w_aceita;
    logic                    w_tick;

    assign w_aceita = valido && r_pronto;
    assign pronto   = r_pronto;
    assign ocupado  = ~r_pronto;
    assign serial   = r_serial;

    transmissor_serial_8bits_divisor_bit #(
        .DIVISOR (DIVISOR)
    ) u_divisor_bit (
        .i_clock (clock),
        .i_reset (reset),
        .i_limpa (w_aceita),
        .o_tick  (w_tick)
    );

    // Frame sequencer: the line value is registered one state ahead of each bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= OCIOSO;
            r_desloc   <= '0;
            r_paridade <= 1'b0;
            r_indice   <= 3'd0;
            r_pronto   <= 1'b1;
            r_serial   <= BIT_PARADA;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_serial <= BIT_PARADA;
                    if (w_aceita) begin
                        r_desloc   <= dado;
                        r_paridade <= paridade_par(dado);
                        r_indice   <= 3'd0;
                        r_pronto   <= 1'b0;
                        r_serial   <= BIT_INICIO;
                        r_estado   <= INICIO;
                    end
                end
                INICIO: begin
                    if (w_tick) begin
                        r_serial <= r_desloc[0];
                        r_indice <= 3'd0;
                        r_estado <= DADOS;
                    end
                end
                DADOS: begin
                    if (w_tick) begin
                        if (r_indice == 3'd7) begin
                            if (HAB_PARIDADE != 0) begin
                                r_serial <= r_paridade;
                                r_estado <= PARIDADE;
                            end else begin
                                r_serial <= BIT_PARADA;
                                r_estado <= PARADA;
                            end
                        end else begin
                            r_desloc <= r_desloc >> 1;
                            r_serial <= r_desloc[1];
                            r_indice <= r_indice + 3'd1;
                        end
                    end
                end
                PARIDADE: begin
                    if (w_tick) begin
                        r_serial <= BIT_PARADA;
                        r_estado <= PARADA;
                    end
                end
                PARADA: begin
                    if (w_tick) begin
                        r_serial <= BIT_PARADA;
                        r_pronto <= 1'b1;
                        r_estado <= OCIOSO;
                    end
                end
                default: begin
                    r_serial <= BIT_PARADA;
                    r_pronto <= 1'b1;
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmissor_serial_8bits.sv
// Directed bench: three transmitter configurations driven from a vector table
// plus hand-written back-to-back and reset-abort sequences.
module tb_transmissor_serial_8bits;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] dado_a = 8'h00, dado_b = 8'h00, dado_c = 8'h00;
    logic       valido_a = 1'b0, valido_b = 1'b0, valido_c = 1'b0;
    logic       pronto_a, pronto_b, pronto_c;
    logic       ocupado_a, ocupado_b, ocupado_c;
    logic       serial_a, serial_b, serial_c;

    int n_vet   = 0;
    int n_erros = 0;

    always #5 clock = ~clock;

    transmissor_serial_8bits #(.DIVISOR(4), .HAB_PARIDADE(0)) u_a (
        .clock(clock), .reset(reset), .dado(dado_a), .valido(valido_a),
        .pronto(pronto_a), .ocupado(ocupado_a), .serial(serial_a));

    transmissor_serial_8bits #(.DIVISOR(4), .HAB_PARIDADE(1)) u_b (
        .clock(clock), .reset(reset), .dado(dado_b), .valido(valido_b),
        .pronto(pronto_b), .ocupado(ocupado_b), .serial(serial_b));

    transmissor_serial_8bits #(.DIVISOR(1), .HAB_PARIDADE(0)) u_c (
        .clock(clock), .reset(reset), .dado(dado_c), .valido(valido_c),
        .pronto(pronto_c), .ocupado(ocupado_c), .serial(serial_c));

    typedef struct {
        int         sel;
        logic [7:0] dado;
        logic [10:0] quadro;   // expected line bits, bit 0 = start bit
        int         n_bits;
        int         pulso;     // cycle offset of an ignored valido pulse, -1 none
        string      nome;
    } vetor_t;

    vetor_t tabela [8];

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_vet++;
        if (atual !== esperado) begin
            n_erros++;
            $display("FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
        end
    endtask

    function automatic logic [2:0] saidas(input int sel);
        case (sel)
            0:       return {pronto_a, ocupado_a, serial_a};
            1:       return {pronto_b, ocupado_b, serial_b};
            default: return {pronto_c, ocupado_c, serial_c};
        endcase
    endfunction

    function automatic int div_de(input int sel);
        return (sel == 2) ? 1 : 4;
    endfunction

    task automatic dirigir(input int sel, input logic [7:0] d, input logic v);
        case (sel)
            0:       begin dado_a = d; valido_a = v; end
            1:       begin dado_b = d; valido_b = v; end
            default: begin dado_c = d; valido_c = v; end
        endcase
    endtask

    task automatic enviar(input vetor_t v);
        int dv;
        int tot;
        dv  = div_de(v.sel);
        tot = v.n_bits * dv;
        @(negedge clock);
        chk({v.nome, " pronto_antes"}, saidas(v.sel), 3'b101);
        dirigir(v.sel, v.dado, 1'b1);
        @(posedge clock); #1;
        dirigir(v.sel, ~v.dado, 1'b0);
        for (int t = 0; t < tot; t++) begin
            if (t > 0) begin
                @(posedge clock); #1;
            end
            if (t == v.pulso) dirigir(v.sel, 8'hFF, 1'b1);
            else if (t == v.pulso + 1) dirigir(v.sel, ~v.dado, 1'b0);
            chk($sformatf("%s bit%0d c%0d", v.nome, t / dv, t), saidas(v.sel),
                {1'b0, 1'b1, v.quadro[t / dv]});
        end
        @(posedge clock); #1;
        chk({v.nome, " pronto_fim"}, saidas(v.sel), 3'b101);
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            chk({v.nome, " ocioso"}, saidas(v.sel), 3'b101);
        end
    endtask

    initial begin
        logic [10:0] q1;
        logic [10:0] q2;
        logic [2:0]  esp;

        tabela[0] = '{0, 8'hA5, 11'b0_1_10100101_0, 10, -1, "A5"};
        tabela[1] = '{0, 8'h00, 11'b0_1_00000000_0, 10, -1, "00"};
        tabela[2] = '{0, 8'h3C, 11'b0_1_00111100_0, 10, 10, "3C_ocupado"};
        tabela[3] = '{1, 8'h07, 11'b1_1_00000111_0, 11, -1, "07_par"};
        tabela[4] = '{1, 8'h03, 11'b1_0_00000011_0, 11, -1, "03_par"};
        tabela[5] = '{1, 8'hFF, 11'b1_0_11111111_0, 11, -1, "FF_par"};
        tabela[6] = '{1, 8'h80, 11'b1_1_10000000_0, 11, -1, "80_par"};
        tabela[7] = '{2, 8'hC3, 11'b0_1_11000011_0, 10, -1, "C3_div1"};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);

        // Asynchronous reset away from any clock edge.
        #3 reset = 1'b1;
        #1;
        chk("reset_a", saidas(0), 3'b101);
        chk("reset_b", saidas(1), 3'b101);
        chk("reset_c", saidas(2), 3'b101);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            chk("pos_reset", {saidas(0), saidas(1), saidas(2)}, 9'b101_101_101);
        end

        for (int i = 0; i < 8; i++) enviar(tabela[i]);

        // Back-to-back with valido held: one idle-high cycle between frames.
        q1 = 11'b0_1_01010101_0;
        q2 = 11'b0_1_10101010_0;
        @(negedge clock);
        dirigir(2, 8'h55, 1'b1);
        @(posedge clock); #1;
        dirigir(2, 8'hAA, 1'b1);
        for (int t = 0; t < 22; t++) begin
            if (t > 0) begin
                @(posedge clock); #1;
            end
            if (t == 11) dirigir(2, 8'h00, 1'b0);
            if (t < 10)       esp = {1'b0, 1'b1, q1[t]};
            else if (t == 10) esp = 3'b101;
            else if (t < 21)  esp = {1'b0, 1'b1, q2[t - 11]};
            else              esp = 3'b101;
            chk($sformatf("b2b c%0d", t), saidas(2), esp);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("b2b_ocioso", saidas(2), 3'b101);
        end

        // Reset during data bit 3 of 0x81.
        q1 = 11'b0_1_10000001_0;
        @(negedge clock);
        dirigir(2, 8'h81, 1'b1);
        @(posedge clock); #1;
        dirigir(2, 8'h00, 1'b0);
        for (int t = 0; t < 5; t++) begin
            if (t > 0) begin
                @(posedge clock); #1;
            end
            chk($sformatf("abort c%0d", t), saidas(2), {1'b0, 1'b1, q1[t]});
        end
        reset = 1'b1;
        #1;
        chk("abort_imediato", saidas(2), 3'b101);
        #2 reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            chk("abort_depois", saidas(2), 3'b101);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_erros);
        $finish;
    end

endmodule
